// File: rtl/memory_controller.sv
// Single-port RAM arbiter: streams icache miss lines byte by byte and serves
// 1/2/4-byte load/store requests over a byte-wide RAM/IO bus.
module memory_controller #(
  parameter int         LINE_BYTES = 4,
  parameter logic [1:0] IO_BASE_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic [7:0]  if_byte,
  output logic        if_valid,
  input  logic        flush,
  input  logic        ls_en,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  localparam int MAX_N = (LINE_BYTES > 4) ? LINE_BYTES : 4;
  localparam int CW    = $clog2(MAX_N + 1);

  typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, LS_DONE} state_t;

  state_t        state;
  logic [31:0]   base_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [CW-1:0] k;
  logic [CW-1:0] n_q;
  logic [CW-1:0] k_prev;
  logic          issued_q;
  logic          issuing;
  logic          if_abort;
  logic          io_stall;

  assign issuing  = ((state == IF_RD) || (state == LS_RD)) && (k < n_q);
  assign if_abort = (state == IF_RD) && (flush || !if_en);
  assign io_stall = (base_q[17:16] == IO_BASE_HI) && io_buffer_full;
  assign k_prev   = k - CW'(1);

  // RAM returns data one cycle after the address, so a byte is valid in the
  // cycle following each issue; an abort kills it in the same cycle.
  assign if_byte  = mem_din;
  assign if_valid = (state == IF_RD) && issued_q && if_en && !flush;
  assign ls_done  = (state == LS_DONE);
  assign ls_rdata = rdata_q;

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (issuing) begin
      mem_a = base_q + 32'(k);
    end else if (state == LS_WR) begin
      mem_a    = base_q + 32'(k);
      mem_dout = wdata_q[{k[1:0], 3'b000} +: 8];
      mem_wr   = !io_stall;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      base_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      k        <= '0;
      n_q      <= '0;
      issued_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          issued_q <= 1'b0;
          k        <= '0;
          if (ls_en) begin
            base_q  <= ls_addr;
            wdata_q <= ls_wdata;
            rdata_q <= '0;
            case (ls_size)
              2'd0:    n_q <= CW'(1);
              2'd1:    n_q <= CW'(2);
              default: n_q <= CW'(4);
            endcase
            state <= ls_wr ? LS_WR : LS_RD;
          end else if (if_en && !flush) begin
            base_q <= if_addr;
            n_q    <= CW'(LINE_BYTES);
            state  <= IF_RD;
          end
        end
        IF_RD: begin
          if (if_abort) begin
            issued_q <= 1'b0;
            state    <= IDLE;
          end else if (issuing) begin
            k        <= k + CW'(1);
            issued_q <= 1'b1;
          end else begin
            issued_q <= 1'b0;
            state    <= IDLE;
          end
        end
        LS_RD: begin
          // the byte arriving now belongs to the previous issue
          if (issued_q)
            rdata_q[{k_prev[1:0], 3'b000} +: 8] <= mem_din;
          if (issuing) begin
            k        <= k + CW'(1);
            issued_q <= 1'b1;
          end else begin
            issued_q <= 1'b0;
            state    <= LS_DONE;
          end
        end
        LS_WR: begin
          if (!io_stall) begin
            if (k == n_q - CW'(1))
              state <= LS_DONE;
            else
              k <= k + CW'(1);
          end
        end
        LS_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_controller.md
# memory_controller

Single-port RAM arbiter serving the instruction fetch path and the load/store buffer. Responder end of the byte-stream fetch protocol: accepts a miss request (enable plus address) from the icache and streams line bytes back one per cycle with a valid strobe. Also serves 1/2/4-byte LSB reads and writes. Sits between the core and the external byte-wide RAM/IO bus.

## Interface
- LINE_BYTES, 4: bytes returned per icache miss, power of two, 1..16.
- IO_BASE_HI, 2'b11: addr[17:16] value marking the IO region.

- clk_in  input  1  clock.
- rst_in  input  1  asynchronous, active-low reset.
- mem_din  input  8  RAM read data; byte for address driven in the previous cycle.
- mem_dout  output  8  RAM write data.
- mem_a  output  32  RAM address.
- mem_wr  output  1  1 = write mem_dout to mem_a this cycle.
- io_buffer_full  input  1  IO write buffer cannot accept a byte.
- if_en  input  1  icache miss request, level; held until the last byte or abort.
- if_addr  input  32  miss line base address, LINE_BYTES-aligned.
- if_byte  output  8  returned byte; combinational copy of mem_din.
- if_valid  output  1  if_byte is the next line byte this cycle.
- flush  input  1  pipeline redirect; aborts any icache transaction.
- ls_en  input  1  LSB request, level; dropped the cycle after ls_done.
- ls_wr  input  1  1 = store, 0 = load.
- ls_size  input  2  0 = 1 B, 1 = 2 B, 2 = 4 B; 3 is illegal.
- ls_addr  input  32  load/store address.
- ls_wdata  input  32  store data, little-endian, low bytes used.
- ls_done  output  1  one-cycle completion pulse.
- ls_rdata  output  32  load data, zero-filled above size; valid while ls_done.

## Operation
- States: IDLE, IF_RD, LS_RD, LS_WR, LS_DONE. Reset enters IDLE.
- IDLE arbitration, in priority order:
  - ls_en: latch addr/size/wdata; go to LS_RD or LS_WR.
  - if_en && !flush: latch if_addr; go to IF_RD.
  - Otherwise stay.
- Inputs are latched at accept and may change afterward.
- Byte counter k runs from 0 to N, where N = LINE_BYTES for IF_RD and 1<<ls_size for LS.
  - Address of byte k = base + k, computed mod 2^32.
  - Counter width is clog2(max(LINE_BYTES,4)+1).
- IF_RD:
  - While k<N: issue mem_a = base+k and increment k.
  - if_valid = 1 in every cycle after an issue cycle, so bytes 0..N-1 arrive in order.
  - The cycle after the last byte, return to IDLE.
  - Abort: flush = 1 or if_en = 0 in any IF_RD cycle. if_valid is forced 0 combinationally in that cycle, the state goes to IDLE next cycle, and no further bytes are flagged.
- LS_RD:
  - Same issue pattern as IF_RD.
  - Byte k is shifted into ls_rdata[8k+7:8k].
  - After the last byte, go to LS_DONE.
  - Not affected by flush.
- LS_WR:
  - Each cycle, drive mem_wr = 1, mem_a = base+k, mem_dout = wdata byte k, then increment k.
  - If addr[17:16] == IO_BASE_HI and io_buffer_full = 1: hold k, drive mem_wr = 0, and retry next cycle.
  - After byte N-1 is written, go to LS_DONE.
- LS_DONE: ls_done = 1; ls_rdata is held; next state IDLE. The ls_en level is ignored in this cycle.
- Idle bus: mem_wr = 0, mem_a = 0, mem_dout = 0.
- Reset mid-transaction: immediate IDLE; no completion or valid is produced.
- Reset values: mem_a = 0, mem_dout = 0, mem_wr = 0, if_valid = 0, ls_done = 0, ls_rdata = 0.

## Timing
- Request sampled in IDLE at cycle T; first issue at T+1.
- IF (N bytes):
  - Issues at T+1..T+N.
  - if_valid at T+2..T+N+1.
  - IDLE at T+N+2; the icache drops if_en by then.
- Load:
  - Issues at T+1..T+N; data arrives T+2..T+N+1.
  - ls_done at T+N+2; IDLE at T+N+3.
- Store:
  - Writes at T+1..T+N, plus one cycle per io_buffer_full stall.
  - ls_done at T+N+1; IDLE at T+N+2.
- ls_en and if_en both high in IDLE: LSB served first. The icache keeps if_en and is served after the LSB transaction's IDLE cycle.
- flush in the same cycle as if_en in IDLE: not accepted.

## Test plan
- Line fetch:
  - Stimulus: RAM[0x100..0x103] = 13,00,50,00; if_en with if_addr = 0x100 at T.
  - Response: mem_a 0x100..0x103 at T+1..T+4; if_valid at T+2..T+5 with bytes 0x13,0x00,0x50,0x00; IDLE at T+6.
- Flush mid-fetch:
  - Stimulus: flush at T+3.
  - Response: if_valid = 0 from T+3 on; IDLE at T+4; a new if_en at T+4 with addr 0x200 yields mem_a = 0x200 at T+5.
- Word load:
  - Stimulus: ls_addr = 0x1000 holding EF,BE,AD,DE; ls_size = 2.
  - Response: ls_done at T+6 with ls_rdata = 0xDEADBEEF. A half-word load of the same address gives 0x0000BEEF with ls_done at T+4.
- IO store with backpressure:
  - Stimulus: ls_addr = 0x30000, size 0, wdata = 0x41; io_buffer_full high during T+1..T+2.
  - Response: mem_wr = 0 at T+1..T+2; mem_wr = 1 with mem_dout = 0x41 at T+3; ls_done at T+4.
- Arbitration:
  - Stimulus: ls_en (store 0x1234 to 0x8, size 1) and if_en both high at T.
  - Response: writes 0x34 to 0x8 and 0x12 to 0x9; ls_done at T+3; fetch issue at T+5.
- Reset and wrap-around:
  - Stimulus: rst_in low during LS_WR; separately, a word load at 0xFFFFFFFE.
  - Response: reset gives all outputs at reset values immediately with no ls_done. The load issues mem_a = 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
